// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative radix-2 multiply/divide unit that owns the HI/LO pair of the
//   pipelined MIPS core. MULT/MULTU/DIV/DIVU take WIDTH+2 busy cycles. MTHI and
//   MTLO write HI/LO directly while idle. A hazard stall is requested whenever
//   the ID instruction touches HI/LO while an operation is issuing or in flight.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op         EX-stage MULT(00)/MULTU(01)/DIV(10)/DIVU(11) issue
//   src_a, src_b      rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   hilo_we/sel/wdata MTHI (sel=1) / MTLO (sel=0) write
//   id_hilo_use       ID instruction reads or writes HI/LO
//   hi, lo            architectural HI/LO
//   busy              operation in flight
//   stall_req         hold PC and IF/ID, flush ID/EX
//   done              one-cycle pulse after an operation updates HI/LO
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepts start or MTHI/MTLO writes
// PREP  | strip signs from the operands, seed accumulator, load counter
// CALC  | one shift-add / shift-subtract step per cycle, WIDTH cycles
// FIX   | sign fix-up and divide-by-zero override, write HI/LO
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  input  logic             id_hilo_use,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed, is_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [2*WIDTH-1:0] prod;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  // Two's complement negation of the most negative value wraps to itself,
  // which read unsigned is exactly its magnitude.
  assign abs_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    sum      = '0;
    shifted  = '0;
    prod     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          state_d = S_PREP;
        end else if (hilo_we) begin
          if (hilo_sel) hi_d = hilo_wdata;
          else          lo_d = hilo_wdata;
        end
      end

      S_PREP: begin
        sign_a_d = is_signed & a_q[WIDTH-1];
        sign_b_d = is_signed & b_q[WIDTH-1];
        a_d      = abs_a;
        b_d      = abs_b;
        acc_hi_d = '0;
        acc_lo_d = is_div ? abs_a : abs_b;
        cnt_d    = CW'(WIDTH - 1);
        state_d  = S_CALC;
      end

      S_CALC: begin
        if (is_div) begin
          // acc_hi is the partial remainder, acc_lo the dividend/quotient.
          shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
          if (shifted >= {1'b0, b_q}) begin
            acc_hi_d = shifted[WIDTH-1:0] - b_q;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = shifted[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Carry out of the add lands in acc_hi's MSB after the shift.
          sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
          {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end

      S_FIX: begin
        if (is_div) begin
          if (b_q == '0) begin
            // a_q holds |src_a|; rebuild the original dividend for HI.
            lo_d = '1;
            hi_d = sign_a_q ? -a_q : a_q;
          end else begin
            lo_d = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
            hi_d = sign_a_q ? -acc_hi_q : acc_hi_q;
          end
        end else begin
          prod = {acc_hi_q, acc_lo_q};
          if (sign_a_q ^ sign_b_q) prod = -prod;
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  // Includes the issue cycle so an MFHI/MFLO right behind MULT/DIV is held.
  assign stall_req = id_hilo_use & (busy | start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         hilo_we = 1'b0, hilo_sel = 1'b0;
  logic [W-1:0] hilo_wdata = '0;
  logic         id_hilo_use = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, stall_req, done;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
    .id_hilo_use(id_hilo_use),
    .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req), .done(done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++; if (hi !== '0)  begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0)  begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    id_hilo_use = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    id_hilo_use = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h12345678; id_hilo_use = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mthi_stall_busy got=%b%b exp=00", stall_req, busy); end
    @(negedge clk);
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    hilo_sel = 1'b0; hilo_wdata = 32'h9ABCDEF0;
    @(negedge clk);
    hilo_we = 1'b0; id_hilo_use = 1'b0;
    checks++; if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
    checks++; if (busy !== 1'b0 || stall_req !== 1'b0) begin failures++; $display("FAIL mtlo_stall_busy got=%b%b exp=00", stall_req, busy); end
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
  endtask

  // Must be entered at a negedge; leaves at the negedge of cycle n+W+3.
  task automatic do_op(input string name, input logic [1:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input bit use_id, input bit we, input bit b2b);
    int cyc;
    checks++; if (done !== b2b) begin failures++; $display("FAIL %s_entry_done got=%b exp=%b", name, done, b2b); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_entry_busy got=%b exp=0", name, busy); end
    start = 1'b1; op = o; src_a = a; src_b = b; id_hilo_use = use_id;
    hilo_we = we; hilo_sel = 1'b1; hilo_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (stall_req !== use_id) begin failures++; $display("FAIL %s_issue_stall got=%b exp=%b", name, stall_req, use_id); end
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      checks++;
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0 || stall_req !== use_id) begin
        failures++;
        $display("FAIL %s_inflight cyc=%0d got hi=%h lo=%h done=%b stall=%b exp hi=%h lo=%h done=0 stall=%b",
                 name, cyc, hi, lo, done, stall_req, m_hi, m_lo, use_id);
      end
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc != W + 2) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, cyc, W + 2); end
    m_hi = eh; m_lo = el;
    checks++; if (hi !== eh) begin failures++; $display("FAIL %s_hi got=%h exp=%h", name, hi, eh); end
    checks++; if (lo !== el) begin failures++; $display("FAIL %s_lo got=%h exp=%h", name, lo, el); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", name, done); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL %s_release_stall got=%b exp=0", name, stall_req); end
    id_hilo_use = 1'b0;
  endtask

  task automatic test_mult();
    @(negedge clk); do_op("mult",  2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0, 1'b0);
    @(negedge clk); do_op("multu", 2'b01, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);
    @(negedge clk); do_op("mult_neg_neg", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    @(negedge clk); do_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0);
    @(negedge clk); do_op("divu_min",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk); do_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk); do_op("div_by0",    2'b10, 32'h00000055, 32'h0,        32'h00000055, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk); do_op("div_neg_by0",2'b10, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk); do_op("divu_100_7", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); do_op("b2b_first",  2'b01, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0, 1'b0, 1'b0);
    do_op("b2b_second", 2'b10, 32'd20, 32'hFFFFFFFA, 32'd2, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_start_priority();
    @(negedge clk); do_op("start_wins", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd12345; src_b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL abort_hilo got hi=%h lo=%h exp 0 0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_busy_done got=%b%b exp=00", busy, done); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op("multu_after_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_back_to_back();
    test_start_priority();
    test_reset_mid_op();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
